// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 keypad scanner.
//   state_t     - scanner FSM states
//   KEYMAP      - key code indexed [row][column]
//   KEY_*       - named codes for the non-digit keys
//   one_low()   - true when exactly one bit of an active-low vector is 0
//   low_index() - index of the single 0 bit of an active-low vector
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN       = 2'd0,
        DB_PRESS   = 2'd1,
        PRESSED    = 2'd2,
        DB_RELEASE = 2'd3
    } state_t;

    localparam logic [3:0] KEY_DEL  = 4'hD;
    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    localparam logic [0:3][0:3][3:0] KEYMAP = '{
        '{4'h1,     4'h2, 4'h3,     4'hA},
        '{4'h4,     4'h5, 4'h6,     4'hB},
        '{4'h7,     4'h8, 4'h9,     4'hC},
        '{KEY_STAR, 4'h0, KEY_HASH, KEY_DEL}
    };

    function automatic logic one_low(input logic [3:0] v);
        logic r;
        case (v)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: r = 1'b1;
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] v);
        logic [1:0] r;
        case (v)
            4'b1101: r = 2'd1;
            4'b1011: r = 2'd2;
            4'b0111: r = 2'd3;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad matrix and key-code output bundle.
//   row    - keypad rows, active-low (keypad -> scanner)
//   col    - column drive, active-low one-cold (scanner -> keypad)
//   BCD    - code of the last accepted key
//   newVal - high while a debounced key is held
// master: the scanner side; slave: the keypad/consumer side.
interface keypad_scanner_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] BCD;
    logic       newVal;

    modport master (input row, output col, output BCD, output newVal);
    modport slave  (output row, input col, input BCD, input newVal);
endinterface

// File: rtl/keypad_sync.sv
// keypad_sync: 4-bit two-flop synchroniser for the asynchronous row inputs.
//   clk   - destination clock
//   reset - asynchronous active-high reset, both stages to 4'hF (no key)
//   d     - asynchronous row bits
//   q     - synchronised row bits
module keypad_sync (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] d,
    output logic [3:0] q
);
    logic [3:0] meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 4'hF;
            q    <= 4'hF;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low keypad, debounces press and release,
// and presents the key code with a held-key level.
//   clk    - system clock
//   reset  - asynchronous active-high reset
//   kp     - keypad_scanner_if.master: row in; col, BCD, newVal out
// BCD only loads on press acceptance, so it is stable across the whole
// newVal pulse and after its falling edge.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 200000
) (
    input  logic clk,
    input  logic reset,
    keypad_scanner_if.master kp
);
    localparam int DW  = (SCAN_DIV > 1)        ? $clog2(SCAN_DIV)        : 1;
    localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);

    state_t         state_q, state_d;
    logic [DW-1:0]  dwell_q;
    logic [DBW-1:0] db_q;
    logic [3:0]     col_q;
    logic [3:0]     row_pat_q;
    logic [1:0]     row_idx_q;
    logic [3:0]     bcd_q;
    logic           nv_q;
    logic [3:0]     row_s;

    logic dwell_end, db_end;
    logic rotate, latch, accept, release_done, db_run;

    keypad_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (kp.row),
        .q     (row_s)
    );

    assign dwell_end = (dwell_q == DWELL_LAST);
    assign db_end    = (db_q == DB_LAST);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= SCAN;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            SCAN:       if (dwell_end && one_low(row_s)) state_d = DB_PRESS;
            DB_PRESS:   if (row_s != row_pat_q)          state_d = SCAN;
                        else if (db_end)                 state_d = PRESSED;
            PRESSED:    if (row_s == 4'hF)               state_d = DB_RELEASE;
            DB_RELEASE: if (row_s != 4'hF)               state_d = PRESSED;
                        else if (db_end)                 state_d = SCAN;
            default:                                     state_d = SCAN;
        endcase
    end

    // Datapath controls. Any exit from a debounce state leaves db_run low,
    // which clears the counter, so it can never run past DB_LAST.
    always_comb begin
        rotate       = 1'b0;
        latch        = 1'b0;
        accept       = 1'b0;
        release_done = 1'b0;
        db_run       = 1'b0;
        case (state_q)
            SCAN: begin
                if (dwell_end) begin
                    if (one_low(row_s)) latch  = 1'b1;
                    else                rotate = 1'b1;  // none or ghosted multi-key
                end
            end
            DB_PRESS: begin
                if (row_s != row_pat_q) rotate = 1'b1;  // resume from next column
                else if (db_end)        accept = 1'b1;
                else                    db_run = 1'b1;
            end
            DB_RELEASE: begin
                if (row_s == 4'hF) begin
                    if (db_end) begin
                        release_done = 1'b1;
                        rotate       = 1'b1;
                    end else begin
                        db_run = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dwell_q   <= '0;
            db_q      <= '0;
            col_q     <= 4'b1110;
            row_pat_q <= 4'hF;
            row_idx_q <= 2'd0;
            bcd_q     <= 4'h0;
            nv_q      <= 1'b0;
        end else begin
            dwell_q <= (state_q == SCAN && !dwell_end) ? dwell_q + 1'b1 : '0;
            db_q    <= db_run ? db_q + 1'b1 : '0;
            if (rotate) col_q <= {col_q[2:0], col_q[3]};
            if (latch) begin
                row_pat_q <= row_s;
                row_idx_q <= low_index(row_s);
            end
            if (accept) begin
                // col is frozen since latch, so its index still names the key
                bcd_q <= KEYMAP[row_idx_q][low_index(col_q)];
                nv_q  <= 1'b1;
            end
            if (release_done) nv_q <= 1'b0;
        end
    end

    assign kp.col    = col_q;
    assign kp.BCD    = bcd_q;
    assign kp.newVal = nv_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner (SCAN_DIV=4,
// DEBOUNCE_CYCLES=8). A keypad model pulls a row low when a held key's
// column is driven. Times are counted in clock edges after reset release,
// sampled 1 time unit after each rising edge.
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] keys = '0;     // bit r*4+c = key at row r, column c held
    logic [3:0]  row_m;
    int          t_now = 0;
    int          n_vec = 0;
    int          n_bad = 0;

    keypad_scanner_if kif ();

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (kif)
    );

    always #5 clk = ~clk;

    always_comb begin
        row_m = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !kif.col[c]) row_m[r] = 1'b0;
    end
    assign kif.row = row_m;

    typedef struct {
        bit          do_rst;
        int          t;
        logic [15:0] keys;
        logic [3:0]  col;
        logic [3:0]  bcd;
        logic        nv;
    } vec_t;

    localparam int NV = 18;
    vec_t vt [NV];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, t_now);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        t_now++;
    endtask

    task automatic advance_to(input int t);
        while (t_now < t) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        t_now = 0;
    endtask

    task automatic wait_nv(input logic val, input int budget, input string name);
        int k = 0;
        while (kif.newVal !== val && k < budget) begin
            tick();
            k++;
        end
        chk(name, kif.newVal, val);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic       hi_seen, ok, prev_nv;
        logic [3:0] prev_col;
        int         rises, changes;

        // Free-running scan, then a clean press/release of key 5 (r1,c1)
        vt[0]  = '{1'b1, 0,  16'h0000, 4'b1110, 4'h0, 1'b0};
        vt[1]  = '{1'b0, 1,  16'h0000, 4'b1110, 4'h0, 1'b0};
        vt[2]  = '{1'b0, 3,  16'h0000, 4'b1110, 4'h0, 1'b0};
        vt[3]  = '{1'b0, 4,  16'h0000, 4'b1101, 4'h0, 1'b0};
        vt[4]  = '{1'b0, 7,  16'h0000, 4'b1101, 4'h0, 1'b0};
        vt[5]  = '{1'b0, 8,  16'h0000, 4'b1011, 4'h0, 1'b0};
        vt[6]  = '{1'b0, 11, 16'h0000, 4'b1011, 4'h0, 1'b0};
        vt[7]  = '{1'b0, 12, 16'h0000, 4'b0111, 4'h0, 1'b0};
        vt[8]  = '{1'b0, 15, 16'h0000, 4'b0111, 4'h0, 1'b0};
        vt[9]  = '{1'b0, 16, 16'h0000, 4'b1110, 4'h0, 1'b0};
        vt[10] = '{1'b1, 0,  16'h0020, 4'b1110, 4'h0, 1'b0};
        vt[11] = '{1'b0, 4,  16'h0020, 4'b1101, 4'h0, 1'b0};
        vt[12] = '{1'b0, 15, 16'h0020, 4'b1101, 4'h0, 1'b0};
        vt[13] = '{1'b0, 16, 16'h0020, 4'b1101, 4'h5, 1'b1};
        vt[14] = '{1'b0, 40, 16'h0000, 4'b1101, 4'h5, 1'b1};
        vt[15] = '{1'b0, 50, 16'h0000, 4'b1101, 4'h5, 1'b1};
        vt[16] = '{1'b0, 51, 16'h0000, 4'b1011, 4'h5, 1'b0};
        vt[17] = '{1'b0, 60, 16'h0000, 4'b1110, 4'h5, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("in-reset col", kif.col, 4'b1110);
        chk("in-reset nv", kif.newVal, 1'b0);

        for (int i = 0; i < NV; i++) begin
            if (vt[i].do_rst) do_reset();
            advance_to(vt[i].t);
            chk($sformatf("v%0d col", i), kif.col, vt[i].col);
            chk($sformatf("v%0d bcd", i), kif.BCD, vt[i].bcd);
            chk($sformatf("v%0d nv", i), kif.newVal, vt[i].nv);
            keys = vt[i].keys;
        end

        // Bouncy press of key D (r3,c3): 3-cycle contact toggling, then stable
        do_reset();
        hi_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            keys = (i % 2 == 0) ? 16'h8000 : 16'h0000;
            repeat (3) begin
                tick();
                if (kif.newVal) hi_seen = 1'b1;
            end
        end
        keys = 16'h8000;
        chk("bounce nv low", hi_seen, 1'b0);
        wait_nv(1'b1, 100, "D accept");
        chk("D bcd", kif.BCD, KEYD());
        rises = 1;
        prev_nv = 1'b1;
        repeat (30) begin
            tick();
            if (kif.newVal && !prev_nv) rises++;
            prev_nv = kif.newVal;
        end
        keys = 16'h0000;
        wait_nv(1'b0, 40, "D release");
        repeat (10) begin
            tick();
            if (kif.newVal && !prev_nv) rises++;
            prev_nv = kif.newVal;
        end
        chk("D single pulse", rises[15:0], 16'd1);
        chk("D bcd held", kif.BCD, 4'hD);

        // Release glitch on key 6 (r1,c2): row back low at debounce count 5
        do_reset();
        keys = 16'h0040;
        advance_to(19);
        chk("k6 nv before", kif.newVal, 1'b0);
        advance_to(20);
        chk("k6 nv accept", kif.newVal, 1'b1);
        chk("k6 bcd", kif.BCD, 4'h6);
        advance_to(30);
        keys = 16'h0000;
        ok = 1'b1;
        while (t_now < 48) begin
            tick();
            if (t_now == 36) keys = 16'h0040;
            if (t_now == 38) keys = 16'h0000;
            if (!kif.newVal) ok = 1'b0;
        end
        chk("glitch nv held", ok, 1'b1);
        tick();
        chk("glitch nv fall", kif.newVal, 1'b0);
        chk("glitch bcd", kif.BCD, 4'h6);

        // Two keys in column 0 (r0,r2): ghost pattern is never accepted
        keys = 16'h0101;
        hi_seen = 1'b0;
        changes = 0;
        prev_col = kif.col;
        repeat (64) begin
            tick();
            if (kif.newVal) hi_seen = 1'b1;
            if (kif.col !== prev_col) changes++;
            prev_col = kif.col;
        end
        chk("ghost nv low", hi_seen, 1'b0);
        chk("ghost col steps", changes[15:0], 16'd16);
        chk("ghost bcd kept", kif.BCD, 4'h6);
        keys = 16'h0000;

        // Reset while key 7 (r2,c0) is held, then re-detection
        do_reset();
        keys = 16'h0100;
        advance_to(11);
        chk("k7 nv before", kif.newVal, 1'b0);
        advance_to(12);
        chk("k7 nv accept", kif.newVal, 1'b1);
        chk("k7 bcd", kif.BCD, 4'h7);
        advance_to(20);
        reset = 1'b1;
        #1;
        chk("async rst nv", kif.newVal, 1'b0);
        chk("async rst bcd", kif.BCD, 4'h0);
        chk("async rst col", kif.col, 4'b1110);
        @(posedge clk);
        #1;
        reset = 1'b0;
        t_now = 0;
        advance_to(11);
        chk("redetect nv before", kif.newVal, 1'b0);
        advance_to(12);
        chk("redetect nv", kif.newVal, 1'b1);
        chk("redetect bcd", kif.BCD, 4'h7);
        ok = 1'b1;
        repeat (30) begin
            tick();
            if (!kif.newVal) ok = 1'b0;
        end
        chk("redetect held", ok, 1'b1);
        keys = 16'h0000;
        wait_nv(1'b0, 40, "k7 release");
        chk("k7 bcd after", kif.BCD, 4'h7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    function automatic logic [3:0] KEYD();
        return 4'hD;
    endfunction

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Upstream stage of the time-entry path.
- Scans a 4x4 matrix keypad, debounces key press and release, and encodes the key as a 4-bit code.
- Presents `BCD` plus a `newVal` level that is high for the debounced duration of the key hold.
- The digit-entry consumer acts on the falling edge of `newVal`, so `BCD` must be stable at and after that edge.

Parameters:
- SCAN_DIV, 1000, clock cycles each column is driven before moving to the next (≥2).
- DEBOUNCE_CYCLES, 200000, consecutive stable cycles required to accept a press or a release (≥2).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- row  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk
- col  output  4  keypad column drive, active-low, exactly one bit low at all times
- BCD  output  4  key code of the last accepted key
- newVal  output  1  high while a debounced key is held

Behaviour:
- Keymap (row r, driven column c → code):
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: E(*), 0, F(#), D
  - Code 4'hD is the delete key.
- `row` passes through a 2-flop synchroniser before any use; all references below are to the synchronised value `row_s`.
- Reset (async, active-high) sets:
  - col=4'b1110, BCD=4'h0, newVal=0
  - state=SCAN, all counters 0
- States: SCAN, DB_PRESS, PRESSED, DB_RELEASE.
- SCAN:
  - Dwell counter counts 0..SCAN_DIV-1 per column.
  - `row_s` is sampled only when the dwell counter = SCAN_DIV-1.
  - If exactly one `row_s` bit is 0: latch row index and column index, keep `col` frozen, clear the debounce counter, go to DB_PRESS.
  - Otherwise (all 1, or two or more 0s, i.e. ghost/multi-key): rotate `col` left (1110→1101→1011→0111→1110) and continue.
- DB_PRESS:
  - Each cycle `row_s` equals the latched one-hot-low pattern: increment the counter.
  - Any other pattern: clear the counter and return to SCAN, resuming the rotation from the next column.
  - Counter reaches DEBOUNCE_CYCLES-1 with a stable pattern: next cycle, `BCD` loads the keymap code, `newVal` goes to 1, state becomes PRESSED. Both updates land in the same clock edge.
- PRESSED:
  - `col` stays frozen; `newVal` stays 1.
  - On `row_s`=4'hF: clear the counter and go to DB_RELEASE.
  - A second key on another row is ignored.
- DB_RELEASE:
  - Each cycle `row_s`=4'hF: increment the counter.
  - Any 0 bit: return to PRESSED; `newVal` stays 1.
  - Counter reaches DEBOUNCE_CYCLES-1: next cycle `newVal` goes to 0, state becomes SCAN, `col` advances to the next column.
- `BCD` changes only on press acceptance and holds its value indefinitely after release. It is never modified while `newVal`=1, nor at the falling edge of `newVal`.
- Minimum `newVal` high width is DEBOUNCE_CYCLES+1 cycles. There is no auto-repeat.
- Press-accept latency from the first synchronised low: DEBOUNCE_CYCLES cycles after entering DB_PRESS. Add 2 sync cycles plus up to 4·SCAN_DIV of scan delay.
- Reset asserted mid-press: `newVal` drops to 0 immediately (async). No falling-edge hold guarantee applies during reset.
- Counters are sized `$clog2` of their parameter. Neither counter can wrap, because it is cleared on every state transition.

Decomposition:
- Shared package `keypad_pkg`:
  - state enum (SCAN, DB_PRESS, PRESSED, DB_RELEASE)
  - keymap constant array [4][4] of 4-bit codes
  - named codes KEY_DEL=4'hD, KEY_STAR=4'hE, KEY_HASH=4'hF
- One sub-module, `keypad_sync`: 4-bit 2-flop synchroniser with async reset to 4'hF.
- FSM, counters and encoder live in `keypad_scanner`.

Test Plan (SCAN_DIV=4, DEBOUNCE_CYCLES=8):
1. Reset, no keys → col cycles 1110, 1101, 1011, 0111, changing every 4 cycles; newVal=0; BCD=0.
2. Clean press of r1,c1 held 40 cycles, then released:
   - BCD=4'h5 and newVal=1 exactly 8 cycles after DB_PRESS entry.
   - newVal falls 9 cycles after row_s returns to 4'hF.
   - BCD remains 5 afterwards.
3. Press of r3,c3 (key D) with 3-cycle bounces (low/high toggling) before settling → no newVal pulse during the bounces. A single newVal high follows stable contact, with BCD=4'hD.
4. Release glitch: during DB_RELEASE, row goes low for 2 cycles at count 5 → newVal stays 1 continuously. It falls only after 8 clean high cycles, giving one pulse total.
5. Two keys in the same column (r0 and r2 low while c0 is driven) → scan continues, newVal stays 0, BCD unchanged.
6. Assert reset while PRESSED with BCD=4'h7 → newVal=0, BCD=0, col=1110 immediately. After reset is released with the key still held, it is re-detected, and BCD=7 and newVal=1 are asserted once.
